// File: rtl/memory_game_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_game_ctrl_pkg
// Description : Shared board geometry, pair-id width and controller state
//               encoding for the 4x4 card-matching game.
// Revision    : 1.0 - initial release
// ============================================================================
package memory_game_ctrl_pkg;

  localparam int GRID_DIM  = 4;
  localparam int NUM_CARDS = GRID_DIM * GRID_DIM;
  localparam int NUM_PAIRS = NUM_CARDS / 2;
  localparam int PAIR_W    = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ONE_UP = 3'd1,
    CHECK  = 3'd2,
    SHOW   = 3'd3,
    WIN    = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/memory_game_ctrl_card_deck.sv
`default_nettype none
// ============================================================================
// Module      : card_deck
// Description : Combinational pair-id ROM. Maps a board position to the id
//               of the pair its card belongs to. Cards i and i+8 share an id.
//               Kept as its own block so a shuffled deck can replace it.
// Ports       : addr - board position 0..15
//               id   - pair id 0..7
// Revision    : 1.0 - initial release
// ============================================================================
module card_deck
  import memory_game_ctrl_pkg::*;
(
  input  logic [3:0]        addr,
  output logic [PAIR_W-1:0] id
);

  always_comb begin
    id = addr[PAIR_W-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/memory_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : memory_game_ctrl
// Description : Game-state controller for the 4x4 card-matching board.
//               Moves a wrapping cursor from button pulses, reveals up to two
//               cards, compares their pair ids, keeps a mismatch visible for
//               SHOW_CYCLES clocks, counts attempts/pairs and flags a win.
// Ports       : clk, rst_n (async, active low), new_game (sync clear)
//               btn_up/down/left/right/sel - single-cycle debounced pulses
//               cursor      - {row, col} of the selected position
//               face_up     - per-card renderer enable
//               matched     - per-card solved flag
//               pairs_found - 0..8
//               attempts    - completed comparisons, saturating at 255
//               busy        - comparison or mismatch display in progress
//               win         - all pairs found
// Revision    : 1.0 - initial release
// ============================================================================
module memory_game_ctrl
  import memory_game_ctrl_pkg::*;
#(
  parameter int SHOW_CYCLES = 25000000,
  parameter int TMR_W       = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        new_game,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_sel,
  output logic [3:0]  cursor,
  output logic [15:0] face_up,
  output logic [15:0] matched,
  output logic [3:0]  pairs_found,
  output logic [7:0]  attempts,
  output logic        busy,
  output logic        win
);

  localparam logic [TMR_W-1:0] c_show_load = TMR_W'(SHOW_CYCLES - 1);
  localparam logic [3:0]       c_last_pair = 4'(NUM_PAIRS - 1);

  state_t             r_state,       w_state_nxt;
  logic [3:0]         r_cursor,      w_cursor_nxt;
  logic [15:0]        r_face_up,     w_face_up_nxt;
  logic [15:0]        r_matched,     w_matched_nxt;
  logic [3:0]         r_pairs_found, w_pairs_found_nxt;
  logic [7:0]         r_attempts,    w_attempts_nxt;
  logic [TMR_W-1:0]   r_timer,       w_timer_nxt;
  logic [3:0]         r_first_sel,   w_first_sel_nxt;
  logic [3:0]         r_second_sel,  w_second_sel_nxt;

  logic [PAIR_W-1:0]  w_first_id;
  logic [PAIR_W-1:0]  w_second_id;
  logic [1:0]         w_row;
  logic [1:0]         w_col;
  logic [1:0]         w_row_dec;
  logic [1:0]         w_row_inc;
  logic [1:0]         w_col_dec;
  logic [1:0]         w_col_inc;
  logic [15:0]        w_cur_mask;
  logic [15:0]        w_pair_mask;
  logic               w_sel_ok;

  card_deck u_deck_first (
    .addr (r_first_sel),
    .id   (w_first_id)
  );

  card_deck u_deck_second (
    .addr (r_second_sel),
    .id   (w_second_id)
  );

  // Two-bit row/col arithmetic gives the wrap-around for free.
  assign w_row     = r_cursor[3:2];
  assign w_col     = r_cursor[1:0];
  assign w_row_dec = w_row - 2'd1;
  assign w_row_inc = w_row + 2'd1;
  assign w_col_dec = w_col - 2'd1;
  assign w_col_inc = w_col + 2'd1;

  assign w_cur_mask  = 16'd1 << r_cursor;
  assign w_pair_mask = (16'd1 << r_first_sel) | (16'd1 << r_second_sel);

  // Select always acts on the pre-move cursor position.
  assign w_sel_ok = btn_sel && !r_face_up[r_cursor] &&
                    ((r_state == IDLE) || (r_state == ONE_UP));

  always_comb begin
    w_state_nxt       = r_state;
    w_cursor_nxt      = r_cursor;
    w_face_up_nxt     = r_face_up;
    w_matched_nxt     = r_matched;
    w_pairs_found_nxt = r_pairs_found;
    w_attempts_nxt    = r_attempts;
    w_timer_nxt       = r_timer;
    w_first_sel_nxt   = r_first_sel;
    w_second_sel_nxt  = r_second_sel;

    if (r_state != WIN) begin
      if (btn_up)          w_cursor_nxt = {w_row_dec, w_col};
      else if (btn_down)   w_cursor_nxt = {w_row_inc, w_col};
      else if (btn_left)   w_cursor_nxt = {w_row, w_col_dec};
      else if (btn_right)  w_cursor_nxt = {w_row, w_col_inc};
    end

    case (r_state)
      IDLE: begin
        if (w_sel_ok) begin
          w_first_sel_nxt = r_cursor;
          w_face_up_nxt   = r_face_up | w_cur_mask;
          w_state_nxt     = ONE_UP;
        end
      end
      ONE_UP: begin
        if (w_sel_ok) begin
          w_second_sel_nxt = r_cursor;
          w_face_up_nxt    = r_face_up | w_cur_mask;
          w_state_nxt      = CHECK;
        end
      end
      CHECK: begin
        if (r_attempts != 8'hFF) w_attempts_nxt = r_attempts + 8'd1;
        if (w_first_id == w_second_id) begin
          w_matched_nxt     = r_matched | w_pair_mask;
          w_pairs_found_nxt = r_pairs_found + 4'd1;
          if (r_pairs_found == c_last_pair) begin
            w_face_up_nxt = '1;
            w_matched_nxt = '1;
            w_state_nxt   = WIN;
          end else begin
            w_state_nxt   = IDLE;
          end
        end else begin
          w_timer_nxt = c_show_load;
          w_state_nxt = SHOW;
        end
      end
      SHOW: begin
        if (r_timer == '0) begin
          w_face_up_nxt = r_face_up & ~w_pair_mask;
          w_state_nxt   = IDLE;
        end else begin
          w_timer_nxt = r_timer - 1'b1;
        end
      end
      WIN: begin
        w_face_up_nxt = '1;
        w_matched_nxt = '1;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cursor      <= '0;
      r_face_up     <= '0;
      r_matched     <= '0;
      r_pairs_found <= '0;
      r_attempts    <= '0;
      r_timer       <= '0;
      r_first_sel   <= '0;
      r_second_sel  <= '0;
    end else if (new_game) begin
      r_state       <= IDLE;
      r_cursor      <= '0;
      r_face_up     <= '0;
      r_matched     <= '0;
      r_pairs_found <= '0;
      r_attempts    <= '0;
      r_timer       <= '0;
      r_first_sel   <= '0;
      r_second_sel  <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cursor      <= w_cursor_nxt;
      r_face_up     <= w_face_up_nxt;
      r_matched     <= w_matched_nxt;
      r_pairs_found <= w_pairs_found_nxt;
      r_attempts    <= w_attempts_nxt;
      r_timer       <= w_timer_nxt;
      r_first_sel   <= w_first_sel_nxt;
      r_second_sel  <= w_second_sel_nxt;
    end
  end

  assign cursor      = r_cursor;
  assign face_up     = r_face_up;
  assign matched     = r_matched;
  assign pairs_found = r_pairs_found;
  assign attempts    = r_attempts;
  assign busy        = (r_state == CHECK) || (r_state == SHOW);
  assign win         = (r_state == WIN);

endmodule
`default_nettype wire

// File: doc/memory_game_ctrl.md
Name: memory_game_ctrl

Overview:
Game-state controller for the 4x4 card-matching board. It sits directly upstream of the sixteen per-position card renderers. Each renderer takes its fixed grid index as pos and face_up[pos] as enable.
Functions: tracks the cursor from debounced button pulses, reveals up to two cards, compares their pair ids, and holds a mismatch visible for a fixed time before hiding it. It also counts attempts and found pairs and flags a win.

Parameters:
SHOW_CYCLES, 25000000, clocks a mismatched pair stays face-up (0.5 s at 50 MHz); 1..2^25-1
TMR_W, 25, timer width; must hold SHOW_CYCLES

Ports:
clk  in  1  system clock (pixel-domain 50 MHz)
rst_n  in  1  asynchronous active-low reset
new_game  in  1  synchronous single-cycle pulse; same effect as reset
btn_up  in  1  single-cycle pulse, debounced upstream
btn_down  in  1  single-cycle pulse
btn_left  in  1  single-cycle pulse
btn_right  in  1  single-cycle pulse
btn_sel  in  1  single-cycle pulse
cursor  out  4  selected grid index, row-major: {row[1:0], col[1:0]}, index 0 = top-left
face_up  out  16  bit i = card i shown face (drives renderer enable)
matched  out  16  bit i = card i permanently solved
pairs_found  out  4  0..8
attempts  out  8  completed two-card comparisons, saturates at 255
busy  out  1  high in CHECK and SHOW
win  out  1  high in WIN

Behaviour:
- Reset (rst_n low, async) or new_game (sync):
  - All outputs go to 0; cursor = 0; state = IDLE; timer = 0; first_sel = 0.
- Pair id: pair_of(i) = i[2:0]. Cards i and i+8 form a pair. Lookup goes through the deck sub-module so a shuffle can replace it later.
- Cursor moves are processed in every state except WIN. Takes effect on the next edge.
  - Priority when several direction pulses arrive together: up > down > left > right. Only one move is applied.
  - Movement wraps within the row/column:
    - up from row 0 goes to row 3; down from row 3 goes to row 0.
    - left from col 0 goes to col 3 in the same row; right from col 3 goes to col 0.
- btn_sel uses the cursor value before any same-cycle move.
  - It is ignored if face_up[cursor] = 1, or if state is CHECK, SHOW or WIN.
- States:
  - IDLE: a valid sel stores first_sel = cursor, sets face_up[cursor] on the next edge, and goes to ONE_UP.
  - ONE_UP: a valid sel stores second_sel, sets face_up[cursor], and goes to CHECK.
  - CHECK (exactly 1 cycle): attempts++ (saturating).
    - Match, pair_of(first) == pair_of(second): set matched for both and pairs_found++. Go to WIN if the new pairs_found = 8, else IDLE.
    - Mismatch: load timer = SHOW_CYCLES-1 and go to SHOW.
  - SHOW: timer decrements each cycle. In the cycle timer == 0, clear face_up for both cards and go to IDLE.
    - Total face-up time of the second card: 1 (CHECK) + SHOW_CYCLES clocks.
  - WIN: all face_up and matched bits are 1 and win = 1. Buttons are ignored; only new_game or reset leaves this state.
- Invariant: matched bits are always a subset of face_up bits. A matched card never returns face-down until new_game or reset.
- Latency: select pulse at edge N gives face_up visible after edge N+1 (registered outputs only, no combinational button-to-output path).
- Reset mid-SHOW: the timer is discarded and all cards hide immediately.

Decomposition:
- Shared package:
  - state encoding constants IDLE/ONE_UP/CHECK/SHOW/WIN
  - GRID_DIM=4, NUM_CARDS=16, NUM_PAIRS=8
  - the pair_of width (3)
- Sub-module card_deck: combinational 16x3 pair-id ROM (addr 4 -> id 3), currently id = addr[2:0].
- Cursor update logic and timer stay in the top.

Test Plan:
1. Reset, then btn_left once -> cursor=3. btn_up -> cursor=15. btn_down -> cursor=3. Pulse btn_up and btn_right in the same cycle -> only up applied, cursor=15.
2. sel at 0, move to 8, sel -> face_up=0x0101 one edge after each sel. CHECK gives matched=0x0101, pairs_found=1, attempts=1, busy high for 1 cycle.
3. SHOW_CYCLES=5: sel 0 then sel 1 -> face_up=0x0003 for exactly 6 clocks after the second sel edge, then 0x0000. Third sel during SHOW is ignored. Cursor moves during SHOW are still applied.
4. Re-select an already face-up card (sel 0 twice) -> state stays ONE_UP, face_up=0x0001, attempts unchanged.
5. Match all 8 pairs (i, i+8) -> win=1, face_up=matched=0xFFFF, pairs_found=8, attempts=8. Buttons are then ignored; new_game gives all outputs 0.
6. Assert rst_n low asynchronously mid-SHOW (between clock edges) -> all outputs 0 immediately. Release -> IDLE accepts a fresh sel.
